// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one common data bus among NUM_FU completion ports.
// Each FU owns a one-entry holding buffer; the oldest buffered result
// (ROB order relative to rob_head_i) is broadcast each cycle.
// Optional macro CDB_ARB_AGE_LIMIT_EN adds per-buffer wait counters that
// override age priority once a buffer has waited MAX_WAIT cycles.
module cdb_arbiter #(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned PRF_IDX_W = 6,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned BR_MASK_W = 4,
  parameter int unsigned MAX_WAIT  = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_FU-1:0]                 fu_vld_i,
  input  logic [NUM_FU*PRF_IDX_W-1:0]       fu_tag_i,
  input  logic [NUM_FU*(ROB_IDX_W+1)-1:0]   fu_rob_idx_i,
  input  logic [NUM_FU*BR_MASK_W-1:0]       fu_br_mask_i,
  output logic [NUM_FU-1:0]                 fu_stall_o,
  input  logic [ROB_IDX_W:0]                rob_head_i,
  input  logic                              rob_br_pred_correct_i,
  input  logic                              rob_br_recovery_i,
  input  logic [BR_MASK_W-1:0]              rob_br_tag_fix_i,
  output logic                              cdb_vld_o,
  output logic [PRF_IDX_W-1:0]              cdb_tag_o,
  output logic [ROB_IDX_W:0]                cdb_rob_idx_o,
  output logic [NUM_FU-1:0]                 cdb_gnt_o
);

  localparam int unsigned RW = ROB_IDX_W + 1;

  // The wait counter is 3 bits wide, so the limit must fit in it.
  if (MAX_WAIT == 0 || MAX_WAIT > 7) begin : g_bad_max_wait
    $error("cdb_arbiter: MAX_WAIT must be in 1..7");
  end

  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_state_e;

  buf_state_e           state_q [NUM_FU];
  buf_state_e           state_d [NUM_FU];
  logic [PRF_IDX_W-1:0] tag_q   [NUM_FU];
  logic [PRF_IDX_W-1:0] tag_d   [NUM_FU];
  logic [RW-1:0]        rob_q   [NUM_FU];
  logic [RW-1:0]        rob_d   [NUM_FU];
  logic [BR_MASK_W-1:0] mask_q  [NUM_FU];
  logic [BR_MASK_W-1:0] mask_d  [NUM_FU];

  logic [RW-1:0]        age     [NUM_FU];
  logic [PRF_IDX_W-1:0] in_tag  [NUM_FU];
  logic [RW-1:0]        in_rob  [NUM_FU];
  logic [BR_MASK_W-1:0] in_mask [NUM_FU];
  logic [NUM_FU-1:0]    full;
  logic [NUM_FU-1:0]    squash_buf;
  logic [NUM_FU-1:0]    squash_in;
  logic [NUM_FU-1:0]    elig;
  logic [NUM_FU-1:0]    accept;
  logic [NUM_FU-1:0]    gnt;
  logic                 pred_clr;

`ifdef CDB_ARB_AGE_LIMIT_EN
  localparam logic [2:0] WAIT_LIM = 3'(MAX_WAIT);
  logic [2:0] wait_q [NUM_FU];
  logic [2:0] wait_d [NUM_FU];
`endif

  // Unpack ports, classify buffers and incoming results for squash/eligibility.
  always_comb begin
    pred_clr = rob_br_pred_correct_i & ~rob_br_recovery_i;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      in_tag[i]     = fu_tag_i[i*PRF_IDX_W +: PRF_IDX_W];
      in_rob[i]     = fu_rob_idx_i[i*RW +: RW];
      in_mask[i]    = fu_br_mask_i[i*BR_MASK_W +: BR_MASK_W];
      full[i]       = (state_q[i] == BUF_FULL);
      squash_buf[i] = rob_br_recovery_i & (|(mask_q[i] & rob_br_tag_fix_i));
      squash_in[i]  = rob_br_recovery_i & fu_vld_i[i] &
                      (|(in_mask[i] & rob_br_tag_fix_i));
      elig[i]       = full[i] & ~squash_buf[i];
      age[i]        = rob_q[i] - rob_head_i;
    end
  end

  // Oldest-first arbitration, lowest index on ties; starved buffers may override.
  always_comb begin
    logic          found;
    logic [RW-1:0] best_age;
    int unsigned   sel;
    found    = 1'b0;
    best_age = '0;
    sel      = 0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (elig[i] && (!found || age[i] < best_age)) begin
        found    = 1'b1;
        best_age = age[i];
        sel      = i;
      end
    end
`ifdef CDB_ARB_AGE_LIMIT_EN
    begin
      logic starved;
      starved = 1'b0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (elig[i] && wait_q[i] == WAIT_LIM && !starved) begin
          starved = 1'b1;
          sel     = i;
        end
      end
    end
`endif
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      gnt[i] = found && (sel == i);
    end
  end

  // Accept/stall handshake and CDB mux driven from the granted buffer.
  always_comb begin
    cdb_tag_o     = '0;
    cdb_rob_idx_o = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      accept[i]     = fu_vld_i[i] & ~squash_in[i] & (~full[i] | gnt[i]);
      fu_stall_o[i] = full[i] & ~gnt[i] & ~squash_in[i];
      if (gnt[i]) begin
        cdb_tag_o     = cdb_tag_o | tag_q[i];
        cdb_rob_idx_o = cdb_rob_idx_o | rob_q[i];
      end
    end
    cdb_gnt_o = gnt;
    cdb_vld_o = |gnt;
  end

  // Per-FU buffer next state: fill, drain, refill on grant, squash, mask fix.
  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      state_d[i] = state_q[i];
      tag_d[i]   = tag_q[i];
      rob_d[i]   = rob_q[i];
      mask_d[i]  = pred_clr ? (mask_q[i] & ~rob_br_tag_fix_i) : mask_q[i];
      if (state_q[i] == BUF_FULL && squash_buf[i]) begin
        state_d[i] = BUF_EMPTY;
      end else if (accept[i]) begin
        state_d[i] = BUF_FULL;
        tag_d[i]   = in_tag[i];
        rob_d[i]   = in_rob[i];
        mask_d[i]  = pred_clr ? (in_mask[i] & ~rob_br_tag_fix_i) : in_mask[i];
      end else if (gnt[i]) begin
        state_d[i] = BUF_EMPTY;
      end
    end
  end

`ifdef CDB_ARB_AGE_LIMIT_EN
  // Wait counters: count ungranted FULL cycles, saturate at 7, clear otherwise.
  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      wait_d[i] = '0;
      if (full[i] && !gnt[i] && !squash_buf[i]) begin
        wait_d[i] = (wait_q[i] == 3'd7) ? 3'd7 : wait_q[i] + 3'd1;
      end
    end
  end

  // Wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_FU; i++) wait_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) wait_q[i] <= wait_d[i];
    end
  end
`endif

  // Buffer state and payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        state_q[i] <= BUF_EMPTY;
        tag_q[i]   <= '0;
        rob_q[i]   <= '0;
        mask_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        state_q[i] <= state_d[i];
        tag_q[i]   <= tag_d[i];
        rob_q[i]   <= rob_d[i];
        mask_q[i]  <= mask_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  fu_vld;
  logic [23:0] fu_tag;
  logic [23:0] fu_rob;
  logic [15:0] fu_mask;
  logic [3:0]  fu_stall;
  logic [5:0]  rob_head;
  logic        pred_ok;
  logic        recov;
  logic [3:0]  tag_fix;
  logic        cdb_vld;
  logic [5:0]  cdb_tag;
  logic [5:0]  cdb_idx;
  logic [3:0]  cdb_gnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_FU(4), .PRF_IDX_W(6), .ROB_IDX_W(5), .BR_MASK_W(4), .MAX_WAIT(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fu_vld_i(fu_vld),
    .fu_tag_i(fu_tag),
    .fu_rob_idx_i(fu_rob),
    .fu_br_mask_i(fu_mask),
    .fu_stall_o(fu_stall),
    .rob_head_i(rob_head),
    .rob_br_pred_correct_i(pred_ok),
    .rob_br_recovery_i(recov),
    .rob_br_tag_fix_i(tag_fix),
    .cdb_vld_o(cdb_vld),
    .cdb_tag_o(cdb_tag),
    .cdb_rob_idx_o(cdb_idx),
    .cdb_gnt_o(cdb_gnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [5:0] tag, input logic [5:0] idx,
                        input logic [3:0] mask);
    fu_vld[i]          = 1'b1;
    fu_tag[i*6 +: 6]   = tag;
    fu_rob[i*6 +: 6]   = idx;
    fu_mask[i*4 +: 4]  = mask;
  endtask

  task automatic clear_inputs();
    fu_vld   = '0;
    fu_tag   = '0;
    fu_rob   = '0;
    fu_mask  = '0;
    rob_head = '0;
    pred_ok  = 1'b0;
    recov    = 1'b0;
    tag_fix  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_fu(i, 6'(i + 1), 6'(i + 1), 4'h0);
    #2;
    total++; if (cdb_vld !== 1'b0) begin $display("FAIL rst_vld got=%b exp=0", cdb_vld); bad++; end
    total++; if (cdb_gnt !== 4'b0000) begin $display("FAIL rst_gnt got=%b exp=0000", cdb_gnt); bad++; end
    total++; if (cdb_tag !== 6'h00) begin $display("FAIL rst_tag got=%h exp=00", cdb_tag); bad++; end
    total++; if (cdb_idx !== 6'h00) begin $display("FAIL rst_idx got=%h exp=00", cdb_idx); bad++; end
    total++; if (fu_stall !== 4'b0000) begin $display("FAIL rst_stall got=%b exp=0000", fu_stall); bad++; end
    tick();
    tick();
    rst = 1'b0;
    fu_vld = 4'b0001;
    #1;
    total++; if (cdb_vld !== 1'b0) begin $display("FAIL first_pre_vld got=%b exp=0", cdb_vld); bad++; end
    tick();
    fu_vld = '0;
    #1;
    total++; if (cdb_vld !== 1'b1) begin $display("FAIL first_vld got=%b exp=1", cdb_vld); bad++; end
    total++; if (cdb_gnt !== 4'b0001) begin $display("FAIL first_gnt got=%b exp=0001", cdb_gnt); bad++; end
    total++; if (cdb_tag !== 6'h01) begin $display("FAIL first_tag got=%h exp=01", cdb_tag); bad++; end
    total++; if (cdb_idx !== 6'h01) begin $display("FAIL first_idx got=%h exp=01", cdb_idx); bad++; end
    tick();
    total++; if (cdb_vld !== 1'b0) begin $display("FAIL first_drain got=%b exp=0", cdb_vld); bad++; end
  endtask

  task automatic test_wrap();
    clear_inputs();
    rob_head = 6'h3E;
    set_fu(0, 6'h10, 6'h01, 4'h0);
    set_fu(1, 6'h11, 6'h3F, 4'h0);
    tick();
    fu_vld = '0;
    #1;
    total++; if (cdb_gnt !== 4'b0010) begin $display("FAIL wrap_gnt0 got=%b exp=0010", cdb_gnt); bad++; end
    total++; if (cdb_tag !== 6'h11) begin $display("FAIL wrap_tag0 got=%h exp=11", cdb_tag); bad++; end
    total++; if (cdb_idx !== 6'h3F) begin $display("FAIL wrap_idx0 got=%h exp=3f", cdb_idx); bad++; end
    total++; if (fu_stall !== 4'b0001) begin $display("FAIL wrap_stall0 got=%b exp=0001", fu_stall); bad++; end
    tick();
    total++; if (cdb_gnt !== 4'b0001) begin $display("FAIL wrap_gnt1 got=%b exp=0001", cdb_gnt); bad++; end
    total++; if (cdb_tag !== 6'h10) begin $display("FAIL wrap_tag1 got=%h exp=10", cdb_tag); bad++; end
    total++; if (fu_stall !== 4'b0000) begin $display("FAIL wrap_stall1 got=%b exp=0000", fu_stall); bad++; end
    tick();
    total++; if (cdb_vld !== 1'b0) begin $display("FAIL wrap_empty got=%b exp=0", cdb_vld); bad++; end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    set_fu(0, 6'h20, 6'h02, 4'h0);
    set_fu(2, 6'h21, 6'h05, 4'h0);
    tick();
    fu_vld[0] = 1'b0;
    #1;
    total++; if (cdb_gnt !== 4'b0001) begin $display("FAIL b2b_gnt0 got=%b exp=0001", cdb_gnt); bad++; end
    total++; if (fu_stall !== 4'b0100) begin $display("FAIL b2b_stall0 got=%b exp=0100", fu_stall); bad++; end
    tick();
    set_fu(2, 6'h22, 6'h06, 4'h0);
    #1;
    total++; if (cdb_gnt !== 4'b0100) begin $display("FAIL b2b_gnt1 got=%b exp=0100", cdb_gnt); bad++; end
    total++; if (cdb_tag !== 6'h21) begin $display("FAIL b2b_tag1 got=%h exp=21", cdb_tag); bad++; end
    total++; if (fu_stall !== 4'b0000) begin $display("FAIL b2b_stall1 got=%b exp=0000", fu_stall); bad++; end
    tick();
    set_fu(2, 6'h23, 6'h07, 4'h0);
    #1;
    total++; if (cdb_gnt !== 4'b0100) begin $display("FAIL b2b_gnt2 got=%b exp=0100", cdb_gnt); bad++; end
    total++; if (cdb_tag !== 6'h22) begin $display("FAIL b2b_tag2 got=%h exp=22", cdb_tag); bad++; end
    tick();
    fu_vld = '0;
    #1;
    total++; if (cdb_tag !== 6'h23) begin $display("FAIL b2b_tag3 got=%h exp=23", cdb_tag); bad++; end
    total++; if (cdb_idx !== 6'h07) begin $display("FAIL b2b_idx3 got=%h exp=07", cdb_idx); bad++; end
    tick();
    total++; if (cdb_vld !== 1'b0) begin $display("FAIL b2b_empty got=%b exp=0", cdb_vld); bad++; end
  endtask

  task automatic test_recovery();
    clear_inputs();
    set_fu(1, 6'h31, 6'h04, 4'b0100);
    set_fu(3, 6'h33, 6'h08, 4'b0001);
    tick();
    fu_vld  = '0;
    recov   = 1'b1;
    tag_fix = 4'b0100;
    #1;
    total++; if (cdb_gnt !== 4'b1000) begin $display("FAIL rec_gnt got=%b exp=1000", cdb_gnt); bad++; end
    total++; if (cdb_tag !== 6'h33) begin $display("FAIL rec_tag got=%h exp=33", cdb_tag); bad++; end
    tick();
    recov   = 1'b0;
    tag_fix = '0;
    #1;
    total++; if (cdb_vld !== 1'b0) begin $display("FAIL rec_squashed got=%b exp=0", cdb_vld); bad++; end
    tick();
  endtask

  // round 0: mask bit cleared survives; round 1: remaining bit still squashes.
  task automatic test_correct_pred(input int round);
    clear_inputs();
    set_fu(1, 6'h29, 6'h00, 4'h0);
    set_fu(2, 6'h2A, 6'h01, 4'h0);
    set_fu(3, 6'h2B, 6'h02, 4'h0);
    set_fu(0, 6'h28, 6'h0A, 4'b0110);
    tick();
    fu_vld  = '0;
    pred_ok = 1'b1;
    tag_fix = 4'b0010;
    #1;
    total++; if (cdb_gnt !== 4'b0010) begin $display("FAIL cp%0d_gnt0 got=%b exp=0010", round, cdb_gnt); bad++; end
    total++; if (fu_stall !== 4'b1101) begin $display("FAIL cp%0d_stall0 got=%b exp=1101", round, fu_stall); bad++; end
    tick();
    pred_ok = 1'b0;
    recov   = 1'b1;
    tag_fix = 4'b0010;
    #1;
    total++; if (cdb_gnt !== 4'b0100) begin $display("FAIL cp%0d_gnt1 got=%b exp=0100", round, cdb_gnt); bad++; end
    tick();
    recov   = (round == 1);
    tag_fix = 4'b0100;
    #1;
    total++; if (cdb_gnt !== 4'b1000) begin $display("FAIL cp%0d_gnt2 got=%b exp=1000", round, cdb_gnt); bad++; end
    tick();
    recov   = 1'b0;
    tag_fix = '0;
    #1;
    if (round == 0) begin
      total++; if (cdb_gnt !== 4'b0001) begin $display("FAIL cp0_gnt3 got=%b exp=0001", cdb_gnt); bad++; end
      total++; if (cdb_tag !== 6'h28) begin $display("FAIL cp0_tag3 got=%h exp=28", cdb_tag); bad++; end
    end else begin
      total++; if (cdb_vld !== 1'b0) begin $display("FAIL cp1_squash got=%b exp=0", cdb_vld); bad++; end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    for (int i = 0; i < 4; i++) set_fu(i, 6'(8 + i), 6'(i), 4'h0);
    tick();
    fu_vld = '0;
    #1;
    total++; if (cdb_gnt !== 4'b0001) begin $display("FAIL mid_pre_gnt got=%b exp=0001", cdb_gnt); bad++; end
    #2;
    rst = 1'b1;
    #1;
    total++; if (cdb_vld !== 1'b0) begin $display("FAIL mid_rst_vld got=%b exp=0", cdb_vld); bad++; end
    total++; if (fu_stall !== 4'b0000) begin $display("FAIL mid_rst_stall got=%b exp=0000", fu_stall); bad++; end
    tick();
    rst = 1'b0;
    tick();
    total++; if (cdb_vld !== 1'b0) begin $display("FAIL mid_discard got=%b exp=0", cdb_vld); bad++; end
  endtask

`ifdef CDB_ARB_AGE_LIMIT_EN
  task automatic test_age_limit();
    clear_inputs();
    set_fu(0, 6'h30, 6'h01, 4'h0);
    set_fu(3, 6'h33, 6'h1E, 4'h0);
    tick();
    fu_vld[3] = 1'b0;
    set_fu(1, 6'h31, 6'h02, 4'h0);
    set_fu(2, 6'h32, 6'h03, 4'h0);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c < 7) begin
        total++; if (cdb_gnt !== 4'b0001) begin $display("FAIL age_gnt_c%0d got=%b exp=0001", c, cdb_gnt); bad++; end
      end else begin
        total++; if (cdb_gnt !== 4'b1000) begin $display("FAIL age_gnt_c7 got=%b exp=1000", cdb_gnt); bad++; end
        total++; if (cdb_tag !== 6'h33) begin $display("FAIL age_tag_c7 got=%h exp=33", cdb_tag); bad++; end
      end
      tick();
    end
    do_reset();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_wrap();
    test_back_to_back();
    test_recovery();
    test_correct_pred(0);
    test_correct_pred(1);
    test_reset_mid();
`ifdef CDB_ARB_AGE_LIMIT_EN
    test_age_limit();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) among NUM_FU functional-unit completion ports.
Each FU result lands in a one-entry holding buffer. Each cycle the oldest buffered result, by ROB order, is granted the CDB; that broadcast wakes reservation-station entries and the ROB.
Losing FUs see back-pressure through a stall signal. Buffered results are squashed or mask-updated on branch resolution.

Parameters:
NUM_FU, 4, number of completion ports
PRF_IDX_W, 6, physical register tag width
ROB_IDX_W, 5, ROB index width; stored indices carry one extra wrap bit (ROB_IDX_W+1 bits)
BR_MASK_W, 4, branch mask width
MAX_WAIT, 7, starvation limit in cycles (only used with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
fu_vld_i  in  NUM_FU  per-FU result valid
fu_tag_i  in  NUM_FU*PRF_IDX_W  per-FU destination tag
fu_rob_idx_i  in  NUM_FU*(ROB_IDX_W+1)  per-FU ROB index with wrap bit
fu_br_mask_i  in  NUM_FU*BR_MASK_W  per-FU branch mask
fu_stall_o  out  NUM_FU  per-FU back-pressure; FU must hold its result while high
rob_head_i  in  ROB_IDX_W+1  ROB head index with wrap bit, used for age
rob_br_pred_correct_i  in  1  branch resolved correct
rob_br_recovery_i  in  1  branch mispredict recovery
rob_br_tag_fix_i  in  BR_MASK_W  one-hot tag of the resolving branch
cdb_vld_o  out  1  CDB broadcast valid
cdb_tag_o  out  PRF_IDX_W  broadcast tag
cdb_rob_idx_o  out  ROB_IDX_W+1  broadcast ROB index
cdb_gnt_o  out  NUM_FU  one-hot grant, for debug and ROB completion

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset state: all buffers invalid, buffered masks 0, wait counters 0.
- Reset outputs: cdb_vld_o=0, cdb_tag_o=0, cdb_rob_idx_o=0, cdb_gnt_o=0, fu_stall_o=0.
- Reset asserted mid-operation discards every buffered result immediately.
- Per-FU buffer state machine, two states:
  - EMPTY -> FULL on fu_vld_i.
  - FULL -> EMPTY on grant with no new fu_vld_i.
  - FULL -> FULL on grant with fu_vld_i (back-to-back refill).
  - FULL -> EMPTY on squash.
- Buffer accept condition: fu_vld_i[i] & (~buf_vld[i] | gnt[i]).
- fu_stall_o[i] = buf_vld[i] & ~gnt[i]. This is combinational, same cycle.
- While stalled, the input is ignored and the FU must re-present the same result.
- Latency: fu_vld_i sampled at edge t; earliest cdb_vld_o is the cycle after t.
- CDB outputs are driven combinationally from the granted buffer (no extra register).
- Age: age_i = buf_rob_idx[i] - rob_head_i, modulo 2^(ROB_IDX_W+1), unsigned.
- Arbitration: smallest age wins; ties go to the lowest FU index.
- cdb_vld_o = |gnt. cdb_gnt_o is one-hot or zero.
- Squash on recovery: when rob_br_recovery_i=1, any buffer with (buf_br_mask & rob_br_tag_fix_i)!=0 is excluded from arbitration that cycle and invalidated at the edge.
- Same rule applies to incoming results: a matching fu_vld_i result is not accepted, and its stall is not asserted for it.
- Non-matching buffers arbitrate normally during recovery.
- Correct prediction: when rob_br_pred_correct_i=1, clear the rob_br_tag_fix_i bits in every buffered mask and in every mask being accepted that cycle.
- Recovery and correct prediction are mutually exclusive; if both are high, recovery wins.
- All FUs valid with empty buffers: all accept. Next cycle one is granted and the rest stall.
- A full set of NUM_FU requests drains in NUM_FU cycles, absent new arrivals.
- ROB wrap: entries straddling the index wrap-around are ordered correctly through the head subtraction.

Optional Feature:
Macro CDB_ARB_AGE_LIMIT_EN.
- Defined:
  - Each FULL buffer carries a 3-bit wait counter, incremented each cycle it is not granted and saturating at 7.
  - The counter is cleared on grant or squash.
  - Any buffer whose counter equals MAX_WAIT overrides age priority; among several such, the lowest index wins.
- Undefined: counters are absent and arbitration is pure oldest-first.

Test Plan:
- Reset: rst high with all fu_vld_i=1 -> all outputs 0. After release, first accept next edge, then cdb_vld_o=1 one cycle later.
- Oldest-first across wrap: rob_head=6'h3E; FU0 idx 6'h01, FU1 idx 6'h3F, same cycle -> FU1 granted first, FU0 next cycle; fu_stall_o=4'b0001 during the first grant.
- Back-pressure and refill: FU2 valid every cycle while FU0 holds an older entry -> FU2 stalls one cycle, never loses a result. On FU2's grant cycle a new result is accepted with no bubble.
- Recovery: FU1 buffered mask 4'b0100, FU3 mask 4'b0001; recovery with tag_fix 4'b0100 -> FU1 never broadcast, FU3 granted the same cycle, FU1 buffer EMPTY next cycle.
- Correct prediction: buffered mask 4'b0110 with pred_correct and tag 4'b0010 -> mask becomes 4'b0100. A later recovery with tag 4'b0010 does not squash it.
- With CDB_ARB_AGE_LIMIT_EN: FU3 young entry, FU0–2 continuously fed older entries -> FU3 granted on the cycle its counter reaches 7.
